// File: rtl/lfsr_bist_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_bist_pkg
// Shared definitions for the LFSR BIST engine:
//   - run mode encodings (pattern generation vs. signature compaction)
//   - engine state encodings
//   - default maximal-length feedback masks for common widths. Bit i set
//     means r[i] contributes to the XOR feedback; the register shifts right
//     and the feedback bit enters at the MSB.
// -----------------------------------------------------------------------------
package lfsr_bist_pkg;

    typedef enum logic {
        MODE_PRPG = 1'b0,
        MODE_MISR = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // x^8  + x^6  + x^5  + x^4  + 1
    localparam logic [7:0]  TAPS_8  = 8'h1D;
    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] TAPS_16 = 16'h002D;
    // x^32 + x^22 + x^2  + x    + 1
    localparam logic [31:0] TAPS_32 = 32'hC000_0401;
    // x^64 + x^63 + x^61 + x^60 + 1
    localparam logic [63:0] TAPS_64 = 64'h0000_0000_0000_001B;

endpackage : lfsr_bist_pkg

// File: rtl/lfsr_bist_next.sv
// -----------------------------------------------------------------------------
// lfsr_bist_next
// Combinational next-value function of the BIST register.
//   PRPG : {fb, r[N-1:1]}
//   MISR : {fb, r[N-1:1]} ^ data_in
// where fb is the XOR reduction of r & TAPS.
//
// Ports:
//   r        in  [N-1:0]  current register value
//   data_in  in  [N-1:0]  response word folded in when mode is MISR
//   mode     in  mode_e   PRPG or MISR
//   r_next   out [N-1:0]  value the register takes on an advance
// -----------------------------------------------------------------------------
module lfsr_bist_next
    import lfsr_bist_pkg::*;
#(
    parameter int             N    = 16,
    parameter logic [N-1:0]   TAPS = N'(TAPS_16)
) (
    input  logic [N-1:0] r,
    input  logic [N-1:0] data_in,
    input  mode_e        mode,
    output logic [N-1:0] r_next
);

    // Even/odd parity of the tapped bits gives the feedback bit.
    function automatic logic feedback_parity(input logic [N-1:0] v);
        return ^v;
    endfunction

    logic           fb_s;
    logic [N-1:0]   shifted_s;

    // Shift right with feedback into the MSB, optionally folding in data_in.
    always_comb begin
        fb_s      = feedback_parity(r & TAPS);
        shifted_s = {fb_s, r[N-1:1]};
        r_next    = shifted_s;
        case (mode)
            MODE_MISR: r_next = shifted_s ^ data_in;
            MODE_PRPG: r_next = shifted_s;
            default:   r_next = shifted_s;
        endcase
    end

endmodule : lfsr_bist_next

// File: rtl/lfsr_bist_engine.sv
// -----------------------------------------------------------------------------
// lfsr_bist_engine
// Runtime-configurable LFSR engine for on-chip test. A run is requested with
// a single-cycle start pulse in IDLE; mode and step count are captured then.
// PRPG advances every RUN cycle, MISR advances only on data_valid. After the
// last advance the engine spends one cycle in DONE (done=1) and returns to
// IDLE, leaving the final value on q for software to read.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (wins over everything)
//   start      in   run request, honoured in IDLE only
//   mode       in   0 = PRPG, 1 = MISR, captured with start
//   count      in   [CNT_W-1:0] steps in the run, captured with start
//   seed_load  in   load seed into the register, honoured in IDLE only
//   seed       in   [N-1:0] value for seed_load
//   data_in    in   [N-1:0] MISR response word
//   data_valid in   qualifies data_in in MISR runs
//   q          out  [N-1:0] current register value
//   busy       out  high while in RUN
//   done       out  one-cycle pulse at the end of a run
//   lockup     out  (only with LFSR_BIST_LOCKUP_DET_EN) sticky flag set when
//                   a PRPG run hit the all-zero state and was reseeded
//
// Configuration macro: LFSR_BIST_LOCKUP_DET_EN enables all-zero recovery in
// PRPG runs and the lockup output. Without it, a zero register stays zero.
// -----------------------------------------------------------------------------
module lfsr_bist_engine
    import lfsr_bist_pkg::*;
#(
    parameter int             N     = 16,
    parameter logic [N-1:0]   TAPS  = N'(TAPS_16),
    parameter logic [N-1:0]   SEED  = {{(N-1){1'b0}}, 1'b1},
    parameter int             CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] count,
    input  logic             seed_load,
    input  logic [N-1:0]     seed,
    input  logic [N-1:0]     data_in,
    input  logic             data_valid,
    output logic [N-1:0]     q,
    output logic             busy,
    output logic             done
`ifdef LFSR_BIST_LOCKUP_DET_EN
    ,
    output logic             lockup
`endif
);

    state_e             state_r;
    state_e             state_next_s;
    logic [N-1:0]       r_r;
    logic [N-1:0]       r_next_s;
    mode_e              mode_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   step_cnt_r;
    logic               advance_s;
    logic               last_step_s;
    logic               lockup_hit_s;

    lfsr_bist_next #(
        .N    (N),
        .TAPS (TAPS)
    ) u_next (
        .r       (r_r),
        .data_in (data_in),
        .mode    (mode_r),
        .r_next  (r_next_s)
    );

    // An advance happens every RUN cycle in PRPG, only on valid data in MISR.
    always_comb begin
        advance_s = 1'b0;
        if (state_r == RUN) begin
            advance_s = (mode_r == MODE_PRPG) || data_valid;
        end else begin
            advance_s = 1'b0;
        end
        // The counter never wraps: it is always strictly below count_r in RUN.
        last_step_s = ((step_cnt_r + CNT_W'(1)) == count_r);
    end

`ifdef LFSR_BIST_LOCKUP_DET_EN
    logic lockup_r;

    // All-zero PRPG state would never leave zero; reseed it instead.
    assign lockup_hit_s = advance_s && (mode_r == MODE_PRPG) && (r_r == '0);

    // Sticky lockup flag, cleared by reset or by the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            lockup_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            lockup_r <= 1'b0;
        end else if (lockup_hit_s) begin
            lockup_r <= 1'b1;
        end
    end

    assign lockup = lockup_r;
`else
    assign lockup_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero-length run goes straight to DONE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = (count == '0) ? DONE : RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (advance_s && last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Outputs decode the registered state, so they change only on clock edges.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            IDLE:    busy = 1'b0;
            default: busy = 1'b0;
        endcase
    end

    // Register, run configuration and step counter. A seed_load together with
    // start lands first; the first advance then works from the new seed.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_r        <= SEED;
            mode_r     <= MODE_PRPG;
            count_r    <= '0;
            step_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (seed_load) begin
                        r_r <= seed;
                    end
                    if (start) begin
                        mode_r     <= mode_e'(mode);
                        count_r    <= count;
                        step_cnt_r <= '0;
                    end
                end
                RUN: begin
                    if (advance_s) begin
                        step_cnt_r <= step_cnt_r + CNT_W'(1);
                        r_r        <= lockup_hit_s ? SEED : r_next_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q = r_r;

endmodule : lfsr_bist_engine

// File: tb/tb_lfsr_bist_engine.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr_bist_engine (default parameters N=16, TAPS=16'h002D,
// SEED=1, CNT_W=16). A behavioural model tracks the register value, busy and
// done; every clock the outputs are compared against it. Directed sequences
// add literal expectations, then randomized runs exercise both modes.
// -----------------------------------------------------------------------------
module tb_lfsr_bist_engine;

    localparam logic [15:0] M_TAPS = 16'h002D;
    localparam logic [15:0] M_SEED = 16'h0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] count = 16'd0;
    logic        seed_load = 1'b0;
    logic [15:0] seed = 16'd0;
    logic [15:0] data_in = 16'd0;
    logic        data_valid = 1'b0;
    logic [15:0] q;
    logic        busy;
    logic        done;
`ifdef LFSR_BIST_LOCKUP_DET_EN
    logic        lockup;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model state
    logic [15:0] m_r;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_misr = 1'b0;
    logic        m_lock = 1'b0;
    int          m_left = 0;

    lfsr_bist_engine dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .count      (count),
        .seed_load  (seed_load),
        .seed       (seed),
        .data_in    (data_in),
        .data_valid (data_valid),
        .q          (q),
        .busy       (busy),
        .done       (done)
`ifdef LFSR_BIST_LOCKUP_DET_EN
        ,
        .lockup     (lockup)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One LFSR step from the polynomial definition: parity of tapped bits
    // becomes the new MSB after a right shift.
    function automatic logic [15:0] m_step(input logic [15:0] r, input logic misr, input logic [15:0] d);
        int ones;
        logic [15:0] n;
        ones = $countones(r & M_TAPS);
        n = (r >> 1) | (16'(ones % 2) << 15);
        if (misr) n = n ^ d;
        return n;
    endfunction

    // Apply the rules for one clock edge using the inputs present at the edge.
    task automatic model_edge();
        if (reset) begin
            m_r = M_SEED; m_busy = 1'b0; m_done = 1'b0; m_lock = 1'b0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (!m_misr || data_valid) begin
`ifdef LFSR_BIST_LOCKUP_DET_EN
                if (!m_misr && m_r == 16'd0) begin
                    m_r = M_SEED; m_lock = 1'b1;
                end else begin
                    m_r = m_step(m_r, m_misr, data_in);
                end
`else
                m_r = m_step(m_r, m_misr, data_in);
`endif
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end else begin
            if (seed_load) m_r = seed;
            if (start) begin
                m_lock = 1'b0;
                m_misr = mode;
                if (count == 16'd0) m_done = 1'b1;
                else begin
                    m_busy = 1'b1; m_left = int'(count);
                end
            end
        end
    endtask

    // Advance one clock, update the model, and compare all outputs.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("q", 32'(q), 32'(m_r));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
`ifdef LFSR_BIST_LOCKUP_DET_EN
        check("lockup", 32'(lockup), 32'(m_lock));
`endif
    endtask

    task automatic idle_inputs();
        start = 1'b0; seed_load = 1'b0; data_valid = 1'b0; reset = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        int guard;

        // Reset
        reset = 1'b1;
        tick(); tick();
        check("reset_q", 32'(q), 32'h0001);
        check("reset_busy", 32'(busy), 32'h0);
        idle_inputs();
        tick();

        // PRPG from seed 1, three steps
        seed_load = 1'b1; seed = 16'h0001; tick();
        seed_load = 1'b0; start = 1'b1; mode = 1'b0; count = 16'd3; tick();
        start = 1'b0;
        busy_cycles = int'(busy);
        tick(); check("prpg_s1", 32'(q), 32'h8000); busy_cycles += int'(busy);
        tick(); check("prpg_s2", 32'(q), 32'h4000); busy_cycles += int'(busy);
        tick(); check("prpg_s3", 32'(q), 32'h2000); check("prpg_done", 32'(done), 32'h1);
        busy_cycles += int'(busy);
        check("prpg_busy_len", 32'(busy_cycles), 32'd3);
        tick(); check("prpg_hold", 32'(q), 32'h2000); check("prpg_done_once", 32'(done), 32'h0);

        // MISR from zero, two valid words with a gap between
        seed_load = 1'b1; seed = 16'h0000; tick();
        seed_load = 1'b0; start = 1'b1; mode = 1'b1; count = 16'd2; tick();
        start = 1'b0;
        data_valid = 1'b1; data_in = 16'h1234; tick(); check("misr_w1", 32'(q), 32'h1234);
        data_valid = 1'b0; data_in = 16'hFFFF; tick(); check("misr_gap", 32'(q), 32'h1234);
        data_valid = 1'b1; data_in = 16'h0001; tick(); check("misr_w2", 32'(q), 32'h091B);
        check("misr_done", 32'(done), 32'h1);
        data_valid = 1'b0; tick();

        // Zero-length run
        start = 1'b1; mode = 1'b0; count = 16'd0; tick();
        start = 1'b0;
        check("cnt0_done", 32'(done), 32'h1); check("cnt0_q", 32'(q), 32'h091B);
        tick();

        // start/seed_load during RUN are ignored
        seed_load = 1'b1; seed = 16'hACE1; tick();
        seed_load = 1'b0; start = 1'b1; mode = 1'b0; count = 16'd10; tick();
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom); seed_load = 1'($urandom); seed = 16'($urandom);
            busy_cycles += int'(busy);
            tick();
        end
        start = 1'b0; seed_load = 1'b0;
        check("run10_busy_len", 32'(busy_cycles), 32'd10);
        check("run10_done", 32'(done), 32'h1);
        tick();

        // Reset in the middle of a run
        start = 1'b1; mode = 1'b0; count = 16'd20; tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; tick();
        check("abort_q", 32'(q), 32'h0001); check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        reset = 1'b0; tick(); check("abort_no_done", 32'(done), 32'h0);

        // All-zero PRPG state
        seed_load = 1'b1; seed = 16'h0000; tick();
        seed_load = 1'b0; start = 1'b1; mode = 1'b0; count = 16'd2; tick();
        start = 1'b0;
`ifdef LFSR_BIST_LOCKUP_DET_EN
        tick(); check("lock_s1", 32'(q), 32'h0001); check("lock_set", 32'(lockup), 32'h1);
        tick(); check("lock_s2", 32'(q), 32'h8000);
        tick(); check("lock_sticky", 32'(lockup), 32'h1);
        start = 1'b1; count = 16'd1; tick(); start = 1'b0;
        check("lock_clear", 32'(lockup), 32'h0);
        tick(); tick();
`else
        tick(); check("zero_s1", 32'(q), 32'h0000);
        tick(); check("zero_s2", 32'(q), 32'h0000);
        tick();
`endif

        // Randomized runs in both modes
        for (int run = 0; run < 40; run++) begin
            seed_load = 1'($urandom); seed = 16'($urandom);
            start = 1'b1; mode = 1'($urandom); count = 16'($urandom_range(0, 20));
            tick();
            start = 1'b0; seed_load = 1'b0;
            guard = 0;
            while ((m_busy || m_done) && guard < 200) begin
                start = 1'($urandom); seed_load = 1'($urandom); seed = 16'($urandom);
                data_valid = 1'($urandom); data_in = 16'($urandom);
                reset = ($urandom_range(0, 63) == 0);
                tick();
                guard++;
            end
            if (guard >= 200) check("run_timeout", 32'd1, 32'd0);
            idle_inputs();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_lfsr_bist_engine

// File: doc/lfsr_bist_engine.md
Name: lfsr_bist_engine

Overview:
- Runtime-configurable LFSR engine for on-chip test.
- Two modes, selected per run: PRPG (pseudo-random pattern generator) or MISR (multiple-input signature register for response compaction).
- Adds features a fixed-polynomial LFSR lacks: parametrised tap mask, runtime seed load, pattern/step counter, start/busy/done handshake.
- Sits between the test controller and the scan/response datapath.

Parameters:
- N, 16, register width (bits), N >= 2.
- TAPS, 16'h002D, feedback mask; bit i set means r[i] is in the XOR feedback. Default gives x^16+x^14+x^13+x^11+1, maximal period 65535.
- SEED, 1, value loaded into r on reset, N bits.
- CNT_W, 16, width of the step counter and the count input.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; sampled in IDLE only.
- mode  in  1  0 = PRPG, 1 = MISR; sampled with start.
- count  in  CNT_W  number of steps in the run; sampled with start.
- seed_load  in  1  loads seed into r; honoured only when not busy.
- seed  in  N  value loaded by seed_load.
- data_in  in  N  MISR response word.
- data_valid  in  1  qualifies data_in; MISR steps only on this.
- q  out  N  current register value r.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse at end of a run.

Behaviour:
- Reset (synchronous): r=SEED, state=IDLE, step counter=0, busy=0, done=0, lockup=0. Reset wins over every other input in the same cycle. Reset during RUN aborts the run with no done pulse.
- Feedback: fb = XOR-reduce(r & TAPS).
- PRPG next state: {fb, r[N-1:1]}.
- MISR next state: {fb, r[N-1:1]} ^ data_in.
- FSM states:
  - IDLE: busy=0. If seed_load, r<=seed. If start and count==0, go to DONE with zero steps. If start and count!=0, latch mode and count, clear the counter, go to RUN. If start and seed_load are high together, load seed first; the run starts from the new seed on the next cycle.
  - RUN: busy=1.
    - PRPG advances r every cycle.
    - MISR advances r only on cycles with data_valid=1; it holds r otherwise.
    - The counter increments on every advance. When an advance makes counter==count, go to DONE that cycle.
    - start and seed_load are ignored in RUN.
  - DONE: done=1 for exactly one cycle, busy=0, r holds, then go to IDLE.
- Latency:
  - start to first PRPG advance: 1 cycle (r changes at the edge after the RUN entry edge).
  - A PRPG run of count=k lasts k cycles in RUN. busy falls, and done rises, on the edge after the k-th advance.
- q = r at all times; it holds after the run so software can read the signature.
- The counter wraps never: the run length is bounded by count, which is at most 2^CNT_W-1.
- An all-zero r in PRPG mode stays zero. This is legal without the optional feature.

Optional Feature:
- Macro: LFSR_BIST_LOCKUP_DET_EN.
- Defined: adds an output port lockup (1 bit, sticky).
  - In RUN with PRPG, if r==0, the next edge loads SEED instead of advancing. That edge still counts as a step, and lockup sets to 1.
  - lockup clears on reset or on the next accepted start.
  - MISR is unaffected.
- Undefined: no lockup port; zero state persists.

Decomposition:
- Package lfsr_bist_pkg holds:
  - mode encodings (MODE_PRPG=0, MODE_MISR=1);
  - state encodings (IDLE, RUN, DONE);
  - default TAPS constants for N = 8, 16, 32, 64.
- Sub-module lfsr_bist_next: combinational next-state function (r, data_in, mode, TAPS -> r_next).
- FSM and counter stay in the top module.

Test Plan:
- reset; PRPG, seed_load seed=16'h0001, start count=3 -> q steps 0x8000, 0x4000, 0x2000; done pulses once; q holds 0x2000; busy high for exactly 3 cycles.
- MISR, seed=0, count=2, data_valid pulses with data_in=0x1234 then 0x0001, with an idle cycle between -> q=0x1234, then hold, then 0x091B; done after the 2nd valid.
- start with count=0 -> no advance, done pulses on the next cycle, q unchanged.
- start and seed_load asserted during RUN (PRPG, count=10) -> ignored; exactly 10 advances.
- reset asserted mid-run at step 5 -> q=SEED (0x0001), busy=0, no done pulse.
- With LFSR_BIST_LOCKUP_DET_EN: PRPG seed=0, count=2 -> q=0x0001 after step 1, 0x8000 after step 2; lockup=1 until the next start.
